// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Opcode, FSM state and PC-source encodings shared by the
//               multi-cycle control FSM and its static strobe decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    typedef logic [6:0] opcode_t;

    localparam opcode_t c_OP_RTYPE  = 7'b0110011;
    localparam opcode_t c_OP_ITYPE  = 7'b0010011;
    localparam opcode_t c_OP_LOAD   = 7'b0000011;
    localparam opcode_t c_OP_STORE  = 7'b0100011;
    localparam opcode_t c_OP_BRANCH = 7'b1100011;
    localparam opcode_t c_OP_JAL    = 7'b1101111;
    localparam opcode_t c_OP_JALR   = 7'b1100111;

    localparam logic [2:0] c_ST_FETCH    = 3'd0;
    localparam logic [2:0] c_ST_DECODE   = 3'd1;
    localparam logic [2:0] c_ST_EXEC     = 3'd2;
    localparam logic [2:0] c_ST_MAC_WAIT = 3'd3;
    localparam logic [2:0] c_ST_MEM      = 3'd4;
    localparam logic [2:0] c_ST_WB       = 3'd5;
    localparam logic [2:0] c_ST_TRAP     = 3'd6;

    localparam logic [1:0] c_PC_SRC_PC4     = 2'd0;
    localparam logic [1:0] c_PC_SRC_PC_IMM  = 2'd1;
    localparam logic [1:0] c_PC_SRC_RS1_IMM = 2'd2;

    function automatic logic op_is_legal(input opcode_t op);
        case (op)
            c_OP_RTYPE, c_OP_ITYPE, c_OP_LOAD, c_OP_STORE,
            c_OP_BRANCH, c_OP_JAL, c_OP_JALR: op_is_legal = 1'b1;
            default:                          op_is_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : Static strobe decode from the latched opcode and FSM state.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] state_i,
    output logic       alu_src_o,
    output logic       mem_to_reg_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       is_legal_o
);

    always_comb begin
        alu_src_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        is_legal_o   = op_is_legal(op_i);
        case (state_i)
            c_ST_EXEC: alu_src_o = (op_i == c_OP_ITYPE) || (op_i == c_OP_LOAD) ||
                                   (op_i == c_OP_STORE) || (op_i == c_OP_JALR);
            c_ST_MEM: begin
                mem_read_o  = (op_i == c_OP_LOAD);
                mem_write_o = (op_i == c_OP_STORE);
            end
            c_ST_WB:   mem_to_reg_o = (op_i == c_OP_LOAD);
            default:   ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle instruction sequencer with memory and MAC stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MAC_LATENCY = 3,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mac_op,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       branch,
    output logic       mac_start,
    output logic       illegal,
    output logic       busy
);

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic             mac_q, mac_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic [6:0] w_dec_op;
    logic       w_is_legal, w_alu_src, w_mem_to_reg, w_mem_read, w_mem_write;
    logic       w_imem_req, w_ir_write, w_pc_write, w_reg_write, w_branch, w_mac_start;
    logic [1:0] w_pc_src;

    // Legality must be judged on the live opcode while DECODE is latching it.
    assign w_dec_op = (state_q == c_ST_DECODE) ? opcode : op_q;

    ctrl_decode u_ctrl_decode (
        .op_i         (w_dec_op),
        .state_i      (state_q),
        .alu_src_o    (w_alu_src),
        .mem_to_reg_o (w_mem_to_reg),
        .mem_read_o   (w_mem_read),
        .mem_write_o  (w_mem_write),
        .is_legal_o   (w_is_legal)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mac_d       = mac_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = c_PC_SRC_PC4;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_mac_start = 1'b0;
        case (state_q)
            c_ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    state_d    = c_ST_DECODE;
                end
            end
            c_ST_DECODE: begin
                op_d  = opcode;
                mac_d = mac_op;
                if (w_is_legal) begin
                    state_d = c_ST_EXEC;
                end else begin
                    state_d   = c_ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            c_ST_EXEC: begin
                case (op_q)
                    c_OP_RTYPE: begin
                        if (mac_q) begin
                            w_mac_start = 1'b1;
                            cnt_d       = CNT_W'(MAC_LATENCY - 1);
                            state_d     = c_ST_MAC_WAIT;
                        end else begin
                            state_d = c_ST_WB;
                        end
                    end
                    c_OP_ITYPE:             state_d = c_ST_WB;
                    c_OP_LOAD, c_OP_STORE:  state_d = c_ST_MEM;
                    c_OP_BRANCH: begin
                        w_branch = 1'b1;
                        if (branch_taken) begin
                            w_pc_write = 1'b1;
                            w_pc_src   = c_PC_SRC_PC_IMM;
                        end
                        state_d = c_ST_FETCH;
                    end
                    c_OP_JAL: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = c_PC_SRC_PC_IMM;
                        state_d    = c_ST_WB;
                    end
                    c_OP_JALR: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = c_PC_SRC_RS1_IMM;
                        state_d    = c_ST_WB;
                    end
                    default:                state_d = c_ST_TRAP;
                endcase
            end
            c_ST_MAC_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = c_ST_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            c_ST_MEM: begin
                if (dmem_ready) begin
                    state_d = (op_q == c_OP_STORE) ? c_ST_FETCH : c_ST_WB;
                end
            end
            c_ST_WB: begin
                w_reg_write = 1'b1;
                state_d     = c_ST_FETCH;
            end
            c_ST_TRAP: ;
            default:   state_d = c_ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_FETCH;
            op_q      <= '0;
            mac_q     <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mac_q     <= mac_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset silences every output immediately, dropping any pending request.
    assign imem_req   = w_imem_req   & ~rst;
    assign ir_write   = w_ir_write   & ~rst;
    assign pc_write   = w_pc_write   & ~rst;
    assign pc_src     = rst ? c_PC_SRC_PC4 : w_pc_src;
    assign reg_write  = w_reg_write  & ~rst;
    assign mem_read   = w_mem_read   & ~rst;
    assign mem_write  = w_mem_write  & ~rst;
    assign mem_to_reg = w_mem_to_reg & ~rst;
    assign alu_src    = w_alu_src    & ~rst;
    assign branch     = w_branch     & ~rst;
    assign mac_start  = w_mac_start  & ~rst;
    assign illegal    = illegal_q    & ~rst;
    assign busy       = (state_q != c_ST_FETCH) & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench: directed vector table, random instruction
//               stream against a per-instruction trace model, corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    typedef logic [6:0] opc_t;

    localparam opc_t c_RTYPE  = 7'b0110011;
    localparam opc_t c_ITYPE  = 7'b0010011;
    localparam opc_t c_LOAD   = 7'b0000011;
    localparam opc_t c_STORE  = 7'b0100011;
    localparam opc_t c_BRANCH = 7'b1100011;
    localparam opc_t c_JAL    = 7'b1101111;
    localparam opc_t c_JALR   = 7'b1100111;

    // Output vector bit map: {imem_req, ir_write, pc_write, pc_src[1:0], reg_write,
    // mem_read, mem_write, mem_to_reg, alu_src, branch, mac_start, illegal, busy}
    localparam logic [13:0] c_E_IMEM = 14'h2000, c_E_IRW  = 14'h1000, c_E_PCW  = 14'h0800;
    localparam logic [13:0] c_E_PCS1 = 14'h0200, c_E_PCS2 = 14'h0400, c_E_REGW = 14'h0100;
    localparam logic [13:0] c_E_MRD  = 14'h0080, c_E_MWR  = 14'h0040, c_E_M2R  = 14'h0020;
    localparam logic [13:0] c_E_ALUS = 14'h0010, c_E_BR   = 14'h0008, c_E_MACS = 14'h0004;
    localparam logic [13:0] c_E_ILL  = 14'h0002, c_E_BUSY = 14'h0001;

    logic clk = 1'b0;
    logic rst, mac_op, branch_taken, imem_ready, dmem_ready;
    logic [6:0] opcode;
    logic a_imem_req, a_ir_write, a_pc_write, a_reg_write, a_mem_read, a_mem_write;
    logic a_mem_to_reg, a_alu_src, a_branch, a_mac_start, a_illegal, a_busy;
    logic [1:0] a_pc_src;
    logic b_imem_req, b_ir_write, b_pc_write, b_reg_write, b_mem_read, b_mem_write;
    logic b_mem_to_reg, b_alu_src, b_branch, b_mac_start, b_illegal, b_busy;
    logic [1:0] b_pc_src;
    logic [13:0] v_a, v_b;

    always #5 clk = ~clk;

    multicycle_control #(.MAC_LATENCY(3), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .mac_op(mac_op), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(a_imem_req),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src), .reg_write(a_reg_write),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_to_reg(a_mem_to_reg),
        .alu_src(a_alu_src), .branch(a_branch), .mac_start(a_mac_start),
        .illegal(a_illegal), .busy(a_busy)
    );

    multicycle_control #(.MAC_LATENCY(1), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .mac_op(mac_op), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(b_imem_req),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src), .reg_write(b_reg_write),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_to_reg(b_mem_to_reg),
        .alu_src(b_alu_src), .branch(b_branch), .mac_start(b_mac_start),
        .illegal(b_illegal), .busy(b_busy)
    );

    assign v_a = {a_imem_req, a_ir_write, a_pc_write, a_pc_src, a_reg_write, a_mem_read,
                  a_mem_write, a_mem_to_reg, a_alu_src, a_branch, a_mac_start, a_illegal, a_busy};
    assign v_b = {b_imem_req, b_ir_write, b_pc_write, b_pc_src, b_reg_write, b_mem_read,
                  b_mem_write, b_mem_to_reg, b_alu_src, b_branch, b_mac_start, b_illegal, b_busy};

    typedef struct { bit irdy; bit drdy; bit bt; bit dec; logic [13:0] exp; } step_t;
    typedef struct { opc_t op; bit mac; bit taken; int iw; int dw; int lat; } vec_t;

    step_t tr[$];
    int    checks = 0;
    int    errors = 0;
    bit    cur_branch, cur_taken;

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic void push(bit irdy, bit drdy, bit dec, logic [13:0] e);
        step_t s;
        s.irdy = irdy; s.drdy = drdy; s.dec = dec; s.exp = e;
        s.bt   = cur_branch ? cur_taken : rb();
        tr.push_back(s);
    endfunction

    // Expected per-cycle outputs of one instruction, phase by phase.
    function automatic void build_trace(opc_t op, bit mac, bit taken, int iw, int dw, int lat);
        tr.delete();
        cur_branch = (op == c_BRANCH);
        cur_taken  = taken;
        for (int i = 0; i < iw; i++) push(1'b0, rb(), 1'b0, c_E_IMEM);
        push(1'b1, rb(), 1'b0, c_E_IMEM | c_E_IRW | c_E_PCW);
        push(rb(), rb(), 1'b1, c_E_BUSY);
        case (op)
            c_RTYPE: begin
                if (mac) begin
                    push(rb(), rb(), 1'b0, c_E_BUSY | c_E_MACS);
                    for (int i = 0; i < lat; i++) push(rb(), rb(), 1'b0, c_E_BUSY);
                end else begin
                    push(rb(), rb(), 1'b0, c_E_BUSY);
                end
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_REGW);
            end
            c_ITYPE: begin
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_ALUS);
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_REGW);
            end
            c_LOAD, c_STORE: begin
                logic [13:0] m;
                m = (op == c_LOAD) ? c_E_MRD : c_E_MWR;
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_ALUS);
                for (int i = 0; i < dw; i++) push(rb(), 1'b0, 1'b0, c_E_BUSY | m);
                push(rb(), 1'b1, 1'b0, c_E_BUSY | m);
                if (op == c_LOAD) push(rb(), rb(), 1'b0, c_E_BUSY | c_E_REGW | c_E_M2R);
            end
            c_BRANCH: push(rb(), rb(), 1'b0,
                           c_E_BUSY | c_E_BR | (taken ? (c_E_PCW | c_E_PCS1) : 14'h0));
            c_JAL: begin
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_PCW | c_E_PCS1);
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_REGW);
            end
            default: begin
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_ALUS | c_E_PCW | c_E_PCS2);
                push(rb(), rb(), 1'b0, c_E_BUSY | c_E_REGW);
            end
        endcase
    endfunction

    function automatic int exp_latency(opc_t op, bit mac, int iw, int dw, int lat);
        int base;
        case (op)
            c_RTYPE:  base = mac ? 4 + lat : 4;
            c_LOAD:   base = 5 + dw;
            c_STORE:  base = 4 + dw;
            c_BRANCH: base = 3;
            default:  base = 4;
        endcase
        return base + iw;
    endfunction

    task automatic check(input string nm, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    // Applies tr[] to one DUT, then confirms the return to FETCH and the latency.
    task automatic run_trace(input bit sel, input opc_t op, input bit mac,
                             input int exp_lat, input string nm);
        logic [13:0] got;
        int lat_meas;
        bit seen_busy;
        lat_meas  = -1;
        seen_busy = 1'b0;
        foreach (tr[k]) begin
            imem_ready   = tr[k].irdy;
            dmem_ready   = tr[k].drdy;
            branch_taken = tr[k].bt;
            opcode       = tr[k].dec ? op  : 7'($urandom);
            mac_op       = tr[k].dec ? mac : rb();
            @(negedge clk);
            got = sel ? v_b : v_a;
            check($sformatf("%s step%0d", nm, k), got, tr[k].exp);
            if (got[0]) seen_busy = 1'b1;
            else if (seen_busy && lat_meas < 0) lat_meas = k;
            @(posedge clk); #1;
        end
        imem_ready = 1'b0;
        opcode     = 7'($urandom);
        @(negedge clk);
        got = sel ? v_b : v_a;
        check({nm, " refetch"}, got, c_E_IMEM);
        if (!got[0] && seen_busy && lat_meas < 0) lat_meas = tr.size();
        checks++;
        if (lat_meas != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d expected %0d", nm, lat_meas, exp_lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        @(negedge clk);
        check({nm, " a"}, v_a, 14'h0);
        check({nm, " b"}, v_b, 14'h0);
        @(posedge clk); #1;
        rst        = 1'b0;
        imem_ready = 1'b0;
    endtask

    task automatic step_check(input string nm, input logic [13:0] exp);
        @(negedge clk);
        check(nm, v_a, exp);
        @(posedge clk); #1;
    endtask

    vec_t tbl[12];

    initial begin
        rst = 1'b1; opcode = '0; mac_op = 1'b0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;

        tbl[0]  = '{c_ITYPE,  1'b0, 1'b0, 0, 0, 4};
        tbl[1]  = '{c_LOAD,   1'b0, 1'b0, 0, 3, 8};
        tbl[2]  = '{c_LOAD,   1'b0, 1'b0, 0, 0, 5};
        tbl[3]  = '{c_STORE,  1'b0, 1'b0, 0, 0, 4};
        tbl[4]  = '{c_STORE,  1'b0, 1'b0, 2, 1, 7};
        tbl[5]  = '{c_RTYPE,  1'b0, 1'b0, 0, 0, 4};
        tbl[6]  = '{c_RTYPE,  1'b1, 1'b0, 0, 0, 7};
        tbl[7]  = '{c_BRANCH, 1'b0, 1'b1, 0, 0, 3};
        tbl[8]  = '{c_BRANCH, 1'b0, 1'b0, 0, 0, 3};
        tbl[9]  = '{c_JAL,    1'b0, 1'b0, 0, 0, 4};
        tbl[10] = '{c_JALR,   1'b0, 1'b0, 0, 0, 4};
        tbl[11] = '{c_ITYPE,  1'b0, 1'b0, 3, 0, 7};

        do_reset("reset");

        for (int i = 0; i < 12; i++) begin
            build_trace(tbl[i].op, tbl[i].mac, tbl[i].taken, tbl[i].iw, tbl[i].dw, 3);
            run_trace(1'b0, tbl[i].op, tbl[i].mac, tbl[i].lat, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 60; i++) begin
            opc_t ops[7];
            opc_t op;
            bit mac, tk;
            int iw, dw;
            ops = '{c_RTYPE, c_ITYPE, c_LOAD, c_STORE, c_BRANCH, c_JAL, c_JALR};
            op  = ops[$urandom_range(0, 6)];
            mac = rb();
            tk  = rb();
            iw  = $urandom_range(0, 3);
            dw  = $urandom_range(0, 3);
            build_trace(op, mac, tk, iw, dw, 3);
            run_trace(1'b0, op, mac, exp_latency(op, mac, iw, (op == c_LOAD || op == c_STORE) ? dw : 0, 3),
                      $sformatf("rnd%0d", i));
        end

        // MAC with single-cycle latency on the second instance.
        do_reset("reset_b");
        build_trace(c_RTYPE, 1'b1, 1'b0, 0, 0, 1);
        run_trace(1'b1, c_RTYPE, 1'b1, 5, "mac_lat1");

        // Illegal opcode traps and stays trapped until reset.
        do_reset("reset_ill");
        imem_ready = 1'b1;
        step_check("ill_fetch", c_E_IMEM | c_E_IRW | c_E_PCW);
        opcode = 7'b1111111;
        step_check("ill_decode", c_E_BUSY);
        for (int i = 0; i < 20; i++) begin
            imem_ready = rb(); dmem_ready = rb(); branch_taken = rb();
            opcode = 7'($urandom); mac_op = rb();
            step_check($sformatf("trap%0d", i), c_E_ILL | c_E_BUSY);
        end
        do_reset("reset_trap");
        step_check("post_trap", c_E_IMEM);

        // Reset lands in the second MEM cycle of a store.
        imem_ready = 1'b1; dmem_ready = 1'b0;
        step_check("st_fetch", c_E_IMEM | c_E_IRW | c_E_PCW);
        opcode = c_STORE;
        step_check("st_decode", c_E_BUSY);
        opcode = 7'($urandom);
        step_check("st_exec", c_E_BUSY | c_E_ALUS);
        step_check("st_mem1", c_E_BUSY | c_E_MWR);
        rst = 1'b1;
        step_check("st_mem2_rst", 14'h0);
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step_check($sformatf("st_after%0d", i), c_E_IMEM);
        build_trace(c_ITYPE, 1'b0, 1'b0, 0, 0, 3);
        run_trace(1'b0, c_ITYPE, 1'b0, 4, "resume");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RISC-V FFT core. It sequences each instruction through fetch, decode, execute, optional memory, and write-back states, stalling on memory ready handshakes and on a parametrised-latency MAC unit. It sits between instruction/data memory handshakes and the single shared datapath. Per-state control strobes drive PC, IR, register-file, memory and ALU-mux enables.

## Interface
Parameters:
- MAC_LATENCY, 3, cycles the MAC unit needs after `mac_start`; legal range 1..15.
- CNT_W, 4, width of the MAC wait counter; must hold MAC_LATENCY-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction opcode from IR; sampled only in DECODE.
- mac_op  in  1  R-type instruction is a MAC; sampled with opcode.
- branch_taken  in  1  ALU compare result; used only in EXEC of a branch.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access completes this cycle.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = rs1+imm.
- reg_write  out  1  write rd.
- mem_read  out  1  data read request.
- mem_write  out  1  data write request.
- mem_to_reg  out  1  write-back source is memory data.
- alu_src  out  1  ALU B operand is the immediate.
- branch  out  1  branch compare active.
- mac_start  out  1  one-cycle MAC launch pulse.
- illegal  out  1  sticky illegal-opcode flag.
- busy  out  1  high in every state except FETCH.

## Operation
- States: FETCH, DECODE, EXEC, MAC_WAIT, MEM, WB, TRAP.
- Outputs are Moore-style, decoded from the state and from `op_q` (the opcode latched in DECODE). `pc_write` in EXEC also depends on `branch_taken`.
- FETCH: `imem_req`=1. When `imem_ready`=1, assert `ir_write`=1, `pc_write`=1 and `pc_src`=0, then go to DECODE. Otherwise hold in FETCH.
- DECODE: latch `opcode` and `mac_op`. An unknown opcode goes to TRAP; any other opcode goes to EXEC. No strobes.
- EXEC, by `op_q`:
  - RTYPE with mac: `mac_start`=1, load counter with MAC_LATENCY-1, go to MAC_WAIT.
  - RTYPE without mac: `alu_src`=0, go to WB.
  - ITYPE: `alu_src`=1, go to WB.
  - LOAD or STORE: `alu_src`=1, go to MEM.
  - BRANCH: `branch`=1. If `branch_taken`, also assert `pc_write`=1 and `pc_src`=1. Go to FETCH.
  - JAL: `pc_write`=1, `pc_src`=1, go to WB.
  - JALR: `alu_src`=1, `pc_write`=1, `pc_src`=2, go to WB.
- MAC_WAIT: if the counter is 0, go to WB; otherwise decrement.
- MEM: hold `mem_read` (LOAD) or `mem_write` (STORE) until `dmem_ready`=1. Then STORE goes to FETCH and LOAD goes to WB.
- WB: `reg_write`=1 for one cycle; `mem_to_reg`=1 only for LOAD. Go to FETCH.
- TRAP: `illegal`=1. All write strobes and requests stay 0. Only `rst` leaves TRAP.
- Opcode encodings are the team's standard RTYPE/ITYPE/LOAD/STORE/BRANCH/JAL/JALR values.

## Timing
- `rst` high at a clock edge:
  - next state is FETCH; `op_q`, counter and `illegal` clear to 0;
  - while `rst` is asserted, every output is forced to 0, including `imem_req` and `busy`;
  - this applies from any state, including mid-MEM and mid-MAC_WAIT: any pending request is dropped with no further strobes.
- Latency with ready signals tied high, in cycles from entering FETCH to re-entering FETCH:
  - ALU/I-type 4; load 5; store 4; branch 3; JAL/JALR 4; MAC 4+MAC_LATENCY.
- Each extra cycle of low `imem_ready` or `dmem_ready` adds exactly one cycle. Request levels stay stable while waiting.
- `mac_start` is high for exactly one cycle per MAC instruction.
- `opcode` changes outside DECODE have no effect.
- `branch_taken` is ignored for non-branch instructions.

## Structure
- Opcode constants stay in the shared opcodes header.
- Add to the same header:
  - the state encoding (3-bit localparams);
  - the `pc_src` encodings.
- One sub-module, `ctrl_decode`: combinational. It maps `op_q` and the state to the static strobes (`alu_src`, `mem_to_reg`, the `mem_read`/`mem_write` selection) and to `is_legal`. The FSM, counter and sticky flag stay in the top module.

## Test plan
- ADDI with ready signals high: exactly 4 cycles; `reg_write` high in cycle 4 only, with `alu_src`=1 and `mem_to_reg`=0.
- LOAD with `dmem_ready` low for 3 MEM cycles: `mem_read` held for 4 cycles, then one WB cycle with `mem_to_reg`=1. Total 8 cycles.
- MAC with MAC_LATENCY=3: single `mac_start` pulse in EXEC, 3 MAC_WAIT cycles, then `reg_write`. Repeat with MAC_LATENCY=1: total 5 cycles.
- BEQ with `branch_taken`=1: `pc_write`=1 and `pc_src`=1 in EXEC. With `branch_taken`=0: `pc_write`=0 in EXEC. Both cases take 3 cycles.
- Opcode 7'b1111111: `illegal` rises on the cycle after DECODE and stays high for 20 cycles with zero strobes. After `rst`, `illegal`=0 and `imem_req`=1.
- `rst` asserted in the second cycle of MEM of a STORE: `mem_write` goes to 0 that cycle, no `reg_write` occurs, and fetch resumes after `rst` deasserts.
